// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_ctrl
// Description : Multi-cycle sequencer for the 16-bit ALU datapath. Steps the
//               A/Q/M registers and the adder/subtractor through add, sub,
//               radix-2 Booth multiply and restoring divide (16 iterations),
//               and drives the external 4-bit iteration counter.
//               Optional macro ALU_SEQ_DIV_EN compiles in the divide states;
//               without it op 11 completes immediately with err=1.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       start,
    input  logic [1:0] op,
    input  logic       q0,
    input  logic       q_m1,
    input  logic       a_msb,
    input  logic [3:0] cnt,
    output logic       ld_op,
    output logic       cnt_clr_b,
    output logic       c_up,
    output logic       alu_add,
    output logic       alu_sub,
    output logic       shr,
    output logic       shl,
    output logic       set_q0,
    output logic       out_en,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [3:0] c_idle    = 4'd0;
    localparam logic [3:0] c_load    = 4'd1;
    localparam logic [3:0] c_exec    = 4'd2;
    localparam logic [3:0] c_b_op    = 4'd3;
    localparam logic [3:0] c_b_shift = 4'd4;
`ifdef ALU_SEQ_DIV_EN
    localparam logic [3:0] c_d_shift = 4'd5;
    localparam logic [3:0] c_d_sub   = 4'd6;
    localparam logic [3:0] c_d_fix   = 4'd7;
`endif
    localparam logic [3:0] c_out     = 4'd8;

    localparam logic [1:0] c_op_add  = 2'b00;
    localparam logic [1:0] c_op_sub  = 2'b01;
    localparam logic [1:0] c_op_mul  = 2'b10;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic [1:0] r_op;
    logic       w_cnt_last;
    logic       w_unsupported;

    assign w_cnt_last = (cnt == 4'hF);

`ifdef ALU_SEQ_DIV_EN
    assign w_unsupported = 1'b0;
`else
    // The divide-restore flag has no consumer when the divide path is absent.
    logic w_unused_a_msb;
    assign w_unused_a_msb = a_msb;
    assign w_unsupported  = (r_op == 2'b11);
`endif

    // State register and operation latch; reset forces IDLE and clears op.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_state <= c_idle;
            r_op    <= 2'b00;
        end else begin
            r_state <= w_next;
            if (r_state == c_idle && start) begin
                r_op <= op;
            end
        end
    end

    // Next-state selection.
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle:    w_next = start ? c_load : c_idle;
            c_load: begin
                case (r_op)
                    c_op_add: w_next = c_exec;
                    c_op_sub: w_next = c_exec;
                    c_op_mul: w_next = c_b_op;
`ifdef ALU_SEQ_DIV_EN
                    default:  w_next = c_d_shift;
`else
                    default:  w_next = c_out;
`endif
                endcase
            end
            c_exec:    w_next = c_out;
            c_b_op:    w_next = c_b_shift;
            c_b_shift: w_next = w_cnt_last ? c_out : c_b_op;
`ifdef ALU_SEQ_DIV_EN
            c_d_shift: w_next = c_d_sub;
            c_d_sub:   w_next = c_d_fix;
            c_d_fix:   w_next = w_cnt_last ? c_out : c_d_shift;
`endif
            c_out:     w_next = c_idle;
            default:   w_next = c_idle;
        endcase
    end

    // Datapath strobes decoded from the state (plus Booth pair / restore bit).
    always_comb begin
        ld_op     = 1'b0;
        cnt_clr_b = 1'b1;
        c_up      = 1'b0;
        alu_add   = 1'b0;
        alu_sub   = 1'b0;
        shr       = 1'b0;
        shl       = 1'b0;
        set_q0    = 1'b0;
        out_en    = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        busy      = (r_state != c_idle);
        case (r_state)
            c_load: begin
                ld_op     = 1'b1;
                cnt_clr_b = 1'b0;
            end
            c_exec: begin
                alu_add = (r_op == c_op_add);
                alu_sub = (r_op == c_op_sub);
            end
            c_b_op: begin
                // Booth recoding: 10 -> subtract M, 01 -> add M, else nothing.
                alu_sub = q0 & ~q_m1;
                alu_add = ~q0 & q_m1;
            end
            c_b_shift: begin
                shr  = 1'b1;
                c_up = 1'b1;
            end
`ifdef ALU_SEQ_DIV_EN
            c_d_shift: shl = 1'b1;
            c_d_sub:   alu_sub = 1'b1;
            c_d_fix: begin
                // Negative trial remainder is restored, otherwise quotient bit set.
                c_up    = 1'b1;
                alu_add = a_msb;
                set_q0  = ~a_msb;
            end
`endif
            c_out: begin
                done   = 1'b1;
                err    = w_unsupported;
                out_en = ~w_unsupported;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Multi-cycle sequencer for the 16-bit ALU datapath. It accepts an operation request, steps the A/Q/M registers and the adder/subtractor through add, subtract, radix-2 Booth multiply or restoring divide, and owns the 4-bit iteration counter through its increment and clear controls. It sits between the processor control unit and the ALU16 register/adder slice and reports completion with a one-cycle `done` strobe.

## Interface
Parameters: none (iteration count fixed at 16).
- `clk` in 1: clock, rising edge.
- `rst_b` in 1: reset, synchronous, active-low.
- `start` in 1: request; sampled only in IDLE.
- `op` in 2: operation select, 00 add, 01 sub, 10 mul, 11 div; sampled with `start`.
- `q0` in 1: Q[0] from the datapath.
- `q_m1` in 1: Booth extra bit Q[-1].
- `a_msb` in 1: A[15] after the divide trial subtract.
- `cnt` in 4: iteration counter value.
- `ld_op` out 1: load operands into A/Q/M and clear Q[-1].
- `cnt_clr_b` out 1: active-low clear to the iteration counter.
- `c_up` out 1: iteration counter increment enable.
- `alu_add`, `alu_sub` out 1 each: perform A<=A+M or A<=A-M this cycle.
- `shr` out 1: arithmetic right shift A:Q:Q[-1] (mul).
- `shl` out 1: left shift A:Q (div).
- `set_q0` out 1: write Q[0]<=1 (div).
- `out_en` out 1: drive the result onto the output bus.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion strobe.
- `err` out 1: unsupported operation, valid with `done`.

## Operation
- States: IDLE, LOAD, EXEC, B_OP, B_SHIFT, D_SHIFT, D_SUB, D_FIX, OUT, plus a latched `op` register.
- IDLE: outputs 0 except `cnt_clr_b`=1. On `start`=1, latch `op` and go to LOAD.
- LOAD: `ld_op`=1 and `cnt_clr_b`=0. Next state: add/sub go to EXEC, mul to B_OP, div to D_SHIFT.
- EXEC: assert `alu_add` (op 00) or `alu_sub` (op 01). Next state OUT.
- B_OP: {q0,q_m1}=10 asserts `alu_sub`; 01 asserts `alu_add`; 00 and 11 assert neither. Next state B_SHIFT.
- B_SHIFT: `shr`=1, `c_up`=1. If `cnt`==15, go to OUT; otherwise go to B_OP.
- D_SHIFT: `shl`=1. Next state D_SUB.
- D_SUB: `alu_sub`=1. Next state D_FIX.
- D_FIX: `c_up`=1. If `a_msb`=1, assert `alu_add` (restore); otherwise assert `set_q0`. If `cnt`==15, go to OUT; otherwise go to D_SHIFT.
- OUT: `out_en`=1 and `done`=1, then go to IDLE.
- Decoded outputs depend on the state only, except B_OP and D_FIX, which also depend on `q0`/`q_m1` and `a_msb`.
- `alu_add` and `alu_sub` are never high together. `shl` and `shr` are never high together.
- The counter wraps 15→0 on the final `c_up`, so it reads 0 again in OUT.

## Timing
- `start` sampled at edge 0. LOAD occupies cycle 1.
- add/sub: EXEC in cycle 2; `done` in cycle 3.
- mul: 16 × (B_OP, B_SHIFT) in cycles 2–33; `done` in cycle 34.
- div: 16 × (D_SHIFT, D_SUB, D_FIX) in cycles 2–49; `done` in cycle 50.
- `start` is ignored while `busy`=1. A new `start` is accepted in the cycle after `done`.
- A `start` held high through OUT is sampled again in IDLE and begins a new operation.
- `rst_b`=0 at any edge, including mid-operation: the next state is IDLE and `op` is cleared to 00. Every output then reads 0 except `cnt_clr_b`=1. The counter is not cleared by this block on reset; it is cleared on the next LOAD.

## Configuration
- `ALU_SEQ_DIV_EN` defined: divide states are compiled in and op 11 runs the restoring divide; `err` is always 0.
- `ALU_SEQ_DIV_EN` undefined: the D_* states are removed. Op 11 runs LOAD→OUT:
  - `done`=1 and `err`=1 in cycle 2.
  - `out_en`=0.
  - No ALU or shift strobes are asserted.

## Test plan
- Reset mid-multiply: assert `rst_b`=0 in cycle 10 → next cycle `busy`=0 with all strobes 0; a following `start` with op 00 gives `done` in cycle 3.
- Add: `start`, op 00 → `ld_op` in cycle 1, `alu_add` in cycle 2, `done`+`out_en` in cycle 3, `busy` low in cycle 4.
- Mul, datapath computing 7×(−3): model the counter from `c_up`/`cnt_clr_b` → exactly 16 `shr` pulses, `alu_sub`/`alu_add` only on Booth bit pairs 10/01, `done` in cycle 34, result −21.
- Div 100÷7 with `ALU_SEQ_DIV_EN` defined → 16 `shl` pulses, 16 `alu_sub` pulses, `done` in cycle 50, Q=14 and A=2.
- Div with `ALU_SEQ_DIV_EN` undefined: op 11 → `done`=1 and `err`=1 in cycle 2, with no `alu_*`, `shl` or `out_en`.
- `start` pulsed at cycles 5 and 20 during a multiply → ignored; exactly one `done`, in cycle 34.
